// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with mid-bit sampling.
//
// The serial line is synchronised into the clk domain, a 1->0 transition
// starts a frame, the start bit is re-checked at its middle, and the eight
// data bits and the stop bit are each sampled one bit time apart from there.
//
// Parameters
//   CLK_FRQ    clk frequency in Hz
//   BAUD_RATE  line bit rate in bit/s
//   BAUD_TIK   clk cycles per bit
//
// Ports
//   clk        system clock, rising-edge active
//   rst        asynchronous active-high reset
//   Rx         serial line, asynchronous to clk, idle high
//   rx_data    last correctly framed byte (LSB received first)
//   rx_valid   one-cycle pulse when rx_data is updated
//   rx_busy    high while a frame is being received
//   frame_err  one-cycle pulse when the stop bit samples low
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FRQ   = 100000000,
    parameter int BAUD_RATE = 9600,
    parameter int BAUD_TIK  = CLK_FRQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int HALF_TIK = BAUD_TIK / 2;

    // Terminal counts of the baud counter for half-bit and full-bit waits.
    localparam logic [15:0] HALF_LAST = 16'(HALF_TIK - 1);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_TIK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic        prev_q, prev_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    logic rx_s;
    logic start_edge;

    // Synchroniser flops reset to the idle level so that reset release does
    // not look like a start edge on an idle line.
    assign rx_s       = sync_q[1];
    assign start_edge = prev_q & ~rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        sync_d  = {sync_q[0], Rx};
        prev_d  = rx_s;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a genuine 1->0 transition starts a frame, so a line
                // held low after a framing error (break) stays ignored.
                if (start_edge) begin
                    cnt_d   = 16'd0;
                    idx_d   = 3'd0;
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 16'd0;
                    // Line back high at mid-start-bit: treat as a glitch.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            DATA: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d   = 16'd0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            STOP: begin
                // Returning to IDLE at mid-stop-bit leaves half a bit of
                // slack to catch a back-to-back start edge.
                if (cnt_q == BAUD_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx at BAUD_TIK=16 (160 ns bits with a
// 10 ns clock).
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    // Free-running monitor state, written only by the always blocks below.
    int cyc        = 0;
    int valid_cnt  = 0;
    int valid_cyc  = 0;
    int ferr_cnt   = 0;
    int busy_cnt   = 0;
    int overlap    = 0;
    int vdbl       = 0;
    int fdbl       = 0;
    logic valid_prev = 1'b0;
    logic ferr_prev  = 1'b0;

    int fall_cyc = 0;

    uart_rx #(
        .CLK_FRQ  (1600),
        .BAUD_RATE(100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Rx       (Rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                valid_cnt <= valid_cnt + 1;
                valid_cyc <= cyc;
            end
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (rx_busy) busy_cnt <= busy_cnt + 1;
            if ((rx_valid || frame_err) && rx_busy) overlap <= overlap + 1;
            if (rx_valid && valid_prev) vdbl <= vdbl + 1;
            if (frame_err && ferr_prev) fdbl <= fdbl + 1;
        end
        valid_prev <= rx_valid;
        ferr_prev  <= frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Drives the first nbits of {stop, data[7:0], start} LSB first.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int bit_ns, input int nbits);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        @(negedge clk);
        fall_cyc = cyc;
        for (int i = 0; i < nbits; i++) begin
            Rx = fr[i];
            #(bit_ns);
        end
    endtask

    int v0, f0, b0, lat;

    initial begin
        // Reset state
        rst = 1'b1;
        Rx  = 1'b1;
        idle(3);
        check("rst_data",  rx_data,   8'h00);
        check("rst_valid", rx_valid,  1'b0);
        check("rst_busy",  rx_busy,   1'b0);
        check("rst_ferr",  frame_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        check("idle_busy", rx_busy, 1'b0);

        // Single frame 0xA5
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        send_frame(8'hA5, 1'b1, 160, 10);
        idle(20);
        lat = valid_cyc - fall_cyc;
        check("a5_data",    rx_data,            8'hA5);
        check("a5_valids",  valid_cnt - v0,     1);
        check("a5_ferr",    ferr_cnt - f0,      0);
        check("a5_busy",    busy_cnt - b0,      152);
        check("a5_latency", (lat >= 154 && lat <= 156), 1'b1);

        // Back-to-back 0x00 then 0xFF with no idle gap
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1, 160, 10);
        check("b2b_first", rx_data, 8'h00);
        send_frame(8'hFF, 1'b1, 160, 10);
        idle(20);
        check("b2b_second", rx_data,        8'hFF);
        check("b2b_valids", valid_cnt - v0, 2);

        // 4-clk low glitch
        v0 = valid_cnt; f0 = ferr_cnt;
        @(negedge clk);
        Rx = 1'b0;
        repeat (4) @(negedge clk);
        Rx = 1'b1;
        #1;
        check("glitch_busy_hi", rx_busy, 1'b1);
        idle(8);
        check("glitch_busy_lo", rx_busy, 1'b0);
        idle(200);
        check("glitch_valids", valid_cnt - v0, 0);
        check("glitch_ferr",   ferr_cnt - f0,  0);

        // Framing error on 0x3C followed by a held-low line
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        send_frame(8'h3C, 1'b0, 160, 10);
        idle(480);
        check("ferr_count",  ferr_cnt - f0,  1);
        check("ferr_valids", valid_cnt - v0, 0);
        check("ferr_data",   rx_data,        8'hFF);
        check("break_busy",  rx_busy,        1'b0);
        check("break_nobusy", busy_cnt - b0, 152);
        Rx = 1'b1;
        idle(40);

        // Reset during bit 4 of 0x5A (bit 4 is 1), then frame 0x81
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h5A, 1'b1, 160, 5);
        Rx = 1'b1;
        #80;
        rst = 1'b1;
        #1;
        check("mid_rst_data",  rx_data,   8'h00);
        check("mid_rst_valid", rx_valid,  1'b0);
        check("mid_rst_busy",  rx_busy,   1'b0);
        check("mid_rst_ferr",  frame_err, 1'b0);
        idle(3);
        @(negedge clk);
        rst = 1'b0;
        idle(200);
        check("post_rst_busy",   rx_busy,        1'b0);
        check("post_rst_valids", valid_cnt - v0, 0);
        check("post_rst_ferr",   ferr_cnt - f0,  0);
        send_frame(8'h81, 1'b1, 160, 10);
        idle(20);
        check("x81_data",   rx_data,        8'h81);
        check("x81_valids", valid_cnt - v0, 1);

        // 0x55 with bit times 3% slow and 3% fast
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b1, 165, 10);
        idle(20);
        check("slow_data",   rx_data,        8'h55);
        check("slow_valids", valid_cnt - v0, 1);
        check("slow_ferr",   ferr_cnt - f0,  0);
        Rx = 1'b1;
        send_frame(8'h00, 1'b1, 160, 10);
        idle(20);
        check("between_data", rx_data, 8'h00);
        v0 = valid_cnt;
        send_frame(8'h55, 1'b1, 155, 10);
        idle(20);
        check("fast_data",   rx_data,        8'h55);
        check("fast_valids", valid_cnt - v0, 1);
        check("fast_ferr",   ferr_cnt - f0,  0);

        // Pulse shape across the whole run
        check("valid_one_cycle", vdbl,    0);
        check("ferr_one_cycle",  fdbl,    0);
        check("idle_on_pulse",   overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
